morty_lsu_ctrl: RTL and testbench
=================================

// Module: morty_lsu_ctrl
// PURPOSE
//  Data-bus controller for the MEM stage. Takes the decoded LSU flags, address and store data.
//  Runs one Wishbone-classic data transaction per load/store.
//  Stalls the pipeline until the transaction ends, then returns the aligned, extended load data and a bus-error flag.
//  Sits between the MEM stage and the data bus. lsu_data_o/lsu_err_o feed the MEM stage's mem_data_i/mem_err_i.
// PARAMETERS
//  TIMEOUT_CYCLES  255  BUS cycles without ack/err before the access is forced to an error
//  CNT_W           8    timeout counter width; must hold TIMEOUT_CYCLES-1
// PORTS
//  clk_i         in   1   clock
//  rst_ni        in   1   reset, synchronous, active-low
//  lsu_flags_i   in   6   {mwrite,mread,mword,mhw,mbyte,munsigned}
//  lsu_addr_i    in   32  byte address (MEM-stage ALU result)
//  lsu_wdata_i   in   32  store data, right-aligned
//  lsu_kill_i    in   1   misaligned access or older trap pending: suppress issue
//  mem_stall_i   in   1   MEM stage held by a downstream stall
//  mem_flush_i   in   1   MEM stage flushed
//  lsu_stall_o   out  1   stall pipeline, access pending
//  lsu_data_o    out  32  load result, extended
//  lsu_err_o     out  1   bus error or timeout on the current access
//  dwb_cyc_o     out  1   Wishbone cycle
//  dwb_stb_o     out  1   Wishbone strobe
//  dwb_we_o      out  1   write enable
//  dwb_sel_o     out  4   byte lanes
//  dwb_addr_o    out  32  word address {addr[31:2],2'b00}
//  dwb_dat_o     out  32  write data, lane-replicated
//  dwb_dat_i     in   32  read data
//  dwb_ack_i     in   1   acknowledge
//  dwb_err_i     in   1   bus error
// BEHAVIOUR
//  Reset (rst_ni=0 at a clk edge)
//   - state=IDLE; every registered output is 0; timeout counter is 0.
//   - lsu_stall_o=0 while rst_ni=0.
//   - Reset during BUS drops cyc/stb on the next edge; a late ack is ignored.
//  req = (mread|mwrite) & !lsu_kill_i & !mem_flush_i
//  FSM IDLE -> BUS -> DONE
//  IDLE
//   - On req: register the bus signals (cyc=stb=1, we=mwrite, sel, addr, dat), clear the counter, go to BUS.
//   - Otherwise hold all bus outputs at 0.
//  BUS (cyc=stb=1)
//   - ack: capture extended data, err=0, drop cyc/stb, go to DONE.
//   - err: err=1, data=0, drop cyc/stb, go to DONE. err wins when ack and err arrive together.
//   - No response and count==TIMEOUT_CYCLES-1: treat as err.
//   - Otherwise increment the counter.
//   - mem_flush_i overrides all of the above: drop cyc/stb, go to IDLE, lsu_err_o=0, no DONE (abort).
//  DONE
//   - lsu_data_o/lsu_err_o held stable.
//   - !mem_stall_i or mem_flush_i: go to IDLE and clear lsu_err_o. lsu_data_o keeps its last value.
//   - mem_stall_i: stay in DONE and never reissue.
//  lsu_stall_o (combinational)
//   - = (req & state==IDLE) | state==BUS. It is 0 in DONE.
//   - Minimum access: 2 stall cycles (IDLE issue, BUS with ack); data is valid in the DONE cycle.
//   - Back-to-back accesses have one IDLE cycle between them.
//  Lanes and alignment
//   - sel: word 4'b1111; hw 4'b0011<<{addr[1],1'b0}; byte 4'b0001<<addr[1:0].
//   - dat: byte {4{wdata[7:0]}}; hw {2{wdata[15:0]}}; word wdata.
//   - Load: sh = dwb_dat_i >> {addr[1:0],3'b0}; byte/hw are sign-extended from bit 7/15, zero-extended if munsigned.
//  Other rules
//   - lsu_kill_i and flags are sampled only in IDLE; changes during BUS are ignored.
//   - Both mread and mwrite set: treated as a store.
// STRUCTURE
//  Package morty_lsu_pkg:
//   - state localparams IDLE/BUS/DONE
//   - flag bit indices MW=5, MR=4, WORD=3, HW=2, BYTE=1, UNS=0
//   - Wishbone sel constants
//  Sub-module morty_lsu_align (combinational): sel/dat generation and load shift/extend.
//  The FSM, counter and output registers stay in morty_lsu_ctrl.
// TESTING
//  1 lw addr 0x100, ack on the first BUS cycle, dat_i 0xDEADBEEF
//    -> sel 4'hF, addr 0x100, stall 2 cycles, lsu_data_o 0xDEADBEEF, err 0
//  2 lb addr 0x103, dat_i 0x80FF_0000; then lbu at the same address
//    -> sel 4'h8, data 0xFFFFFF80; lbu -> 0x00000080
//  3 sh addr 0x202, wdata 0x1234ABCD
//    -> we 1, sel 4'hC, dat_o 0xABCDABCD
//  4 Load with ack withheld, TIMEOUT_CYCLES=4
//    -> cyc high 4 cycles, then DONE with lsu_err_o 1; ack+err in the same cycle -> err 1
//  5 mem_flush_i in the second BUS cycle, ack in the same cycle
//    -> cyc 0 on the next edge, state IDLE, lsu_err_o 0, no DONE
//  6 mem_stall_i held 3 cycles in DONE; separately lsu_kill_i with lw; then rst_ni=0 mid-BUS
//    -> DONE: single bus cycle, no reissue; kill: no cyc, stall 0; reset: all outputs 0 next edge

Source files
------------

// File: rtl/morty_lsu_pkg.sv
// Shared types and constants for the MEM-stage data-bus controller.
// Flag bit positions follow the decoder's {mwrite,mread,mword,mhw,mbyte,munsigned} packing.
package morty_lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } lsu_size_e;

   localparam int unsigned MW   = 5;
   localparam int unsigned MR   = 4;
   localparam int unsigned WORD = 3;
   localparam int unsigned HW   = 2;
   localparam int unsigned BYTE = 1;
   localparam int unsigned UNS  = 0;

   localparam logic [3:0] SEL_BYTE = 4'b0001;
   localparam logic [3:0] SEL_HALF = 4'b0011;
   localparam logic [3:0] SEL_WORD = 4'b1111;

   // A flag set with no size bit is treated as a full word.
   function automatic lsu_size_e flags_to_size(input logic [5:0] flags);
      if (flags[WORD])      return SZ_WORD;
      else if (flags[HW])   return SZ_HALF;
      else if (flags[BYTE]) return SZ_BYTE;
      else                  return SZ_WORD;
   endfunction

endpackage

// File: rtl/morty_lsu_align.sv
// Byte-lane generation for stores and shift/extend of load data.
// Purely combinational; store side uses the live address, load side the issued one.
module morty_lsu_align
   import morty_lsu_pkg::*;
(
   input  lsu_size_e   st_size_i,
   input  logic [1:0]  st_off_i,
   input  logic [31:0] wdata_i,
   output logic [3:0]  sel_o,
   output logic [31:0] dat_o,
   input  lsu_size_e   ld_size_i,
   input  logic [1:0]  ld_off_i,
   input  logic        ld_uns_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] ldata_o
);

   logic [31:0] sh;

   always_comb begin
      sel_o = SEL_WORD;
      dat_o = wdata_i;
      unique case (st_size_i)
         SZ_BYTE: begin
            sel_o = SEL_BYTE << st_off_i;
            dat_o = {4{wdata_i[7:0]}};
         end
         SZ_HALF: begin
            sel_o = SEL_HALF << {st_off_i[1], 1'b0};
            dat_o = {2{wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      sh      = rdata_i >> {ld_off_i, 3'b000};
      ldata_o = sh;
      unique case (ld_size_i)
         SZ_BYTE: ldata_o = {{24{sh[7] & ~ld_uns_i}}, sh[7:0]};
         SZ_HALF: ldata_o = {{16{sh[15] & ~ld_uns_i}}, sh[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/morty_lsu_ctrl.sv
// MEM-stage data-bus controller: one Wishbone-classic transaction per load/store,
// stalling the pipeline until ack, bus error, timeout or flush ends the access.
module morty_lsu_ctrl
   import morty_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [5:0]  lsu_flags_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   input  logic        lsu_kill_i,
   input  logic        mem_stall_i,
   input  logic        mem_flush_i,
   output logic        lsu_stall_o,
   output logic [31:0] lsu_data_o,
   output logic        lsu_err_o,
   output logic        dwb_cyc_o,
   output logic        dwb_stb_o,
   output logic        dwb_we_o,
   output logic [3:0]  dwb_sel_o,
   output logic [31:0] dwb_addr_o,
   output logic [31:0] dwb_dat_o,
   input  logic [31:0] dwb_dat_i,
   input  logic        dwb_ack_i,
   input  logic        dwb_err_i
);

   lsu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
   logic [3:0]       sel_q, sel_d;
   logic [31:0]      addr_q, addr_d, dat_q, dat_d, data_q, data_d;
   logic             err_q, err_d;
   lsu_size_e        ld_size_q, ld_size_d;
   logic [1:0]       ld_off_q, ld_off_d;
   logic             ld_uns_q, ld_uns_d;

   logic             req;
   logic             timeout;
   logic [3:0]       st_sel;
   logic [31:0]      st_dat, ld_data;

   assign req     = (lsu_flags_i[MR] | lsu_flags_i[MW]) & ~lsu_kill_i & ~mem_flush_i;
   assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   assign lsu_stall_o = rst_ni & ((req & (state_q == IDLE)) | (state_q == BUS));
   assign lsu_data_o  = data_q;
   assign lsu_err_o   = err_q;
   assign dwb_cyc_o   = cyc_q;
   assign dwb_stb_o   = stb_q;
   assign dwb_we_o    = we_q;
   assign dwb_sel_o   = sel_q;
   assign dwb_addr_o  = addr_q;
   assign dwb_dat_o   = dat_q;

   morty_lsu_align u_align (
      .st_size_i (flags_to_size(lsu_flags_i)),
      .st_off_i  (lsu_addr_i[1:0]),
      .wdata_i   (lsu_wdata_i),
      .sel_o     (st_sel),
      .dat_o     (st_dat),
      .ld_size_i (ld_size_q),
      .ld_off_i  (ld_off_q),
      .ld_uns_i  (ld_uns_q),
      .rdata_i   (dwb_dat_i),
      .ldata_o   (ld_data)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cyc_d     = cyc_q;
      stb_d     = stb_q;
      we_d      = we_q;
      sel_d     = sel_q;
      addr_d    = addr_q;
      dat_d     = dat_q;
      data_d    = data_q;
      err_d     = err_q;
      ld_size_d = ld_size_q;
      ld_off_d  = ld_off_q;
      ld_uns_d  = ld_uns_q;

      unique case (state_q)
         IDLE: begin
            cyc_d  = 1'b0;
            stb_d  = 1'b0;
            we_d   = 1'b0;
            sel_d  = '0;
            addr_d = '0;
            dat_d  = '0;
            if (req) begin
               cyc_d     = 1'b1;
               stb_d     = 1'b1;
               we_d      = lsu_flags_i[MW];
               sel_d     = st_sel;
               addr_d    = {lsu_addr_i[31:2], 2'b00};
               dat_d     = st_dat;
               cnt_d     = '0;
               ld_size_d = flags_to_size(lsu_flags_i);
               ld_off_d  = lsu_addr_i[1:0];
               ld_uns_d  = lsu_flags_i[UNS];
               state_d   = BUS;
            end
         end
         BUS: begin
            // Flush aborts even a same-cycle response; the result is discarded.
            if (mem_flush_i) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               err_d   = 1'b0;
               state_d = IDLE;
            end else if (dwb_err_i || (!dwb_ack_i && timeout)) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               err_d   = 1'b1;
               data_d  = '0;
               state_d = DONE;
            end else if (dwb_ack_i) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               err_d   = 1'b0;
               data_d  = ld_data;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (!mem_stall_i || mem_flush_i) begin
               err_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         addr_q    <= '0;
         dat_q     <= '0;
         data_q    <= '0;
         err_q     <= 1'b0;
         ld_size_q <= SZ_BYTE;
         ld_off_q  <= '0;
         ld_uns_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cyc_q     <= cyc_d;
         stb_q     <= stb_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         addr_q    <= addr_d;
         dat_q     <= dat_d;
         data_q    <= data_d;
         err_q     <= err_d;
         ld_size_q <= ld_size_d;
         ld_off_q  <= ld_off_d;
         ld_uns_q  <= ld_uns_d;
      end
   end

endmodule

// File: tb/tb_morty_lsu_ctrl.sv
// Directed bench for morty_lsu_ctrl with hand-computed expectations.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_morty_lsu_ctrl;

   localparam logic [5:0] F_LW  = 6'b011000;
   localparam logic [5:0] F_LB  = 6'b010010;
   localparam logic [5:0] F_LBU = 6'b010011;
   localparam logic [5:0] F_SH  = 6'b100100;
   localparam logic [5:0] F_SWR = 6'b111000;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [5:0]  lsu_flags_i;
   logic [31:0] lsu_addr_i, lsu_wdata_i;
   logic        lsu_kill_i, mem_stall_i, mem_flush_i;
   logic        lsu_stall_o, lsu_err_o;
   logic [31:0] lsu_data_o;
   logic        dwb_cyc_o, dwb_stb_o, dwb_we_o;
   logic [3:0]  dwb_sel_o;
   logic [31:0] dwb_addr_o, dwb_dat_o, dwb_dat_i;
   logic        dwb_ack_i, dwb_err_i;

   int tests = 0;
   int fails = 0;
   int n;

   always #5 clk_i = ~clk_i;

   morty_lsu_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .lsu_flags_i (lsu_flags_i),
      .lsu_addr_i  (lsu_addr_i),
      .lsu_wdata_i (lsu_wdata_i),
      .lsu_kill_i  (lsu_kill_i),
      .mem_stall_i (mem_stall_i),
      .mem_flush_i (mem_flush_i),
      .lsu_stall_o (lsu_stall_o),
      .lsu_data_o  (lsu_data_o),
      .lsu_err_o   (lsu_err_o),
      .dwb_cyc_o   (dwb_cyc_o),
      .dwb_stb_o   (dwb_stb_o),
      .dwb_we_o    (dwb_we_o),
      .dwb_sel_o   (dwb_sel_o),
      .dwb_addr_o  (dwb_addr_o),
      .dwb_dat_o   (dwb_dat_o),
      .dwb_dat_i   (dwb_dat_i),
      .dwb_ack_i   (dwb_ack_i),
      .dwb_err_i   (dwb_err_i)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // From an IDLE-bound cycle: present a request, end on the first BUS cycle.
   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk_i);
      lsu_flags_i = f;
      lsu_addr_i  = a;
      lsu_wdata_i = wd;
      #1 check("issue_stall", {31'd0, lsu_stall_o}, 32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      lsu_flags_i = '0;
      check("bus_cyc", {31'd0, dwb_cyc_o}, 32'd1);
      check("bus_stb", {31'd0, dwb_stb_o}, 32'd1);
      check("bus_stall", {31'd0, lsu_stall_o}, 32'd1);
   endtask

   // Drive one response cycle in BUS; ends on the DONE cycle.
   task automatic respond(input logic a, input logic e, input logic [31:0] d);
      dwb_ack_i = a;
      dwb_err_i = e;
      dwb_dat_i = d;
      @(posedge clk_i);
      @(negedge clk_i);
      dwb_ack_i = 1'b0;
      dwb_err_i = 1'b0;
      check("done_cyc", {31'd0, dwb_cyc_o}, 32'd0);
      check("done_stall", {31'd0, lsu_stall_o}, 32'd0);
   endtask

   initial begin
      rst_ni      = 1'b0;
      lsu_flags_i = '0;
      lsu_addr_i  = '0;
      lsu_wdata_i = '0;
      lsu_kill_i  = 1'b0;
      mem_stall_i = 1'b0;
      mem_flush_i = 1'b0;
      dwb_dat_i   = '0;
      dwb_ack_i   = 1'b0;
      dwb_err_i   = 1'b0;
      repeat (2) @(posedge clk_i);

      // reset: stall held low even with a live request
      @(negedge clk_i);
      lsu_flags_i = F_LW;
      lsu_addr_i  = 32'h100;
      #1 check("rst_stall", {31'd0, lsu_stall_o}, 32'd0);
      check("rst_cyc", {31'd0, dwb_cyc_o}, 32'd0);
      check("rst_sel", {28'd0, dwb_sel_o}, 32'd0);
      check("rst_data", lsu_data_o, 32'd0);
      check("rst_err", {31'd0, lsu_err_o}, 32'd0);
      lsu_flags_i = '0;
      rst_ni = 1'b1;

      // 1: lw 0x100
      issue(F_LW, 32'h100, 32'h0);
      check("lw_sel", {28'd0, dwb_sel_o}, 32'hF);
      check("lw_addr", dwb_addr_o, 32'h100);
      check("lw_we", {31'd0, dwb_we_o}, 32'd0);
      respond(1'b1, 1'b0, 32'hDEADBEEF);
      check("lw_data", lsu_data_o, 32'hDEADBEEF);
      check("lw_err", {31'd0, lsu_err_o}, 32'd0);

      // 2: lb / lbu at 0x103
      issue(F_LB, 32'h103, 32'h0);
      check("lb_sel", {28'd0, dwb_sel_o}, 32'h8);
      check("lb_addr", dwb_addr_o, 32'h100);
      respond(1'b1, 1'b0, 32'h80FF_0000);
      check("lb_data", lsu_data_o, 32'hFFFFFF80);
      issue(F_LBU, 32'h103, 32'h0);
      respond(1'b1, 1'b0, 32'h80FF_0000);
      check("lbu_data", lsu_data_o, 32'h00000080);

      // 3: sh 0x202, then store with both read and write flags
      issue(F_SH, 32'h202, 32'h1234ABCD);
      check("sh_we", {31'd0, dwb_we_o}, 32'd1);
      check("sh_sel", {28'd0, dwb_sel_o}, 32'hC);
      check("sh_dat", dwb_dat_o, 32'hABCDABCD);
      check("sh_addr", dwb_addr_o, 32'h200);
      respond(1'b1, 1'b0, 32'h0);
      check("sh_err", {31'd0, lsu_err_o}, 32'd0);
      issue(F_SWR, 32'h304, 32'h000055AA);
      check("swr_we", {31'd0, dwb_we_o}, 32'd1);
      check("swr_sel", {28'd0, dwb_sel_o}, 32'hF);
      check("swr_dat", dwb_dat_o, 32'h000055AA);
      respond(1'b1, 1'b0, 32'h0);

      // 4: timeout after 4 BUS cycles, then ack+err together
      issue(F_LW, 32'h108, 32'h0);
      n = 0;
      while (dwb_cyc_o === 1'b1 && n < 20) begin
         n++;
         @(posedge clk_i);
         @(negedge clk_i);
      end
      check("to_cycles", n, 32'd4);
      check("to_err", {31'd0, lsu_err_o}, 32'd1);
      check("to_data", lsu_data_o, 32'd0);
      check("to_stall", {31'd0, lsu_stall_o}, 32'd0);
      issue(F_LW, 32'h10C, 32'h0);
      respond(1'b1, 1'b1, 32'h12345678);
      check("ackerr_err", {31'd0, lsu_err_o}, 32'd1);
      check("ackerr_data", lsu_data_o, 32'd0);

      // 5: flush in second BUS cycle with same-cycle ack
      issue(F_LW, 32'h400, 32'h0);
      @(posedge clk_i);
      @(negedge clk_i);
      check("fl_cyc_bus2", {31'd0, dwb_cyc_o}, 32'd1);
      mem_flush_i = 1'b1;
      dwb_ack_i   = 1'b1;
      dwb_dat_i   = 32'h11112222;
      @(posedge clk_i);
      @(negedge clk_i);
      mem_flush_i = 1'b0;
      dwb_ack_i   = 1'b0;
      check("fl_cyc", {31'd0, dwb_cyc_o}, 32'd0);
      check("fl_err", {31'd0, lsu_err_o}, 32'd0);
      check("fl_data", lsu_data_o, 32'd0);
      lsu_flags_i = F_LW;
      lsu_addr_i  = 32'h404;
      #1 check("fl_idle_stall", {31'd0, lsu_stall_o}, 32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      lsu_flags_i = '0;
      respond(1'b1, 1'b0, 32'h0BADF00D);
      check("fl_next_data", lsu_data_o, 32'h0BADF00D);

      // 6a: DONE held by mem_stall_i with request still present
      issue(F_LW, 32'h500, 32'h0);
      mem_stall_i = 1'b1;
      respond(1'b1, 1'b0, 32'hCAFEF00D);
      lsu_flags_i = F_LW;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         check("hold_cyc", {31'd0, dwb_cyc_o}, 32'd0);
         check("hold_stall", {31'd0, lsu_stall_o}, 32'd0);
         check("hold_data", lsu_data_o, 32'hCAFEF00D);
      end
      mem_stall_i = 1'b0;
      lsu_flags_i = '0;
      @(posedge clk_i);
      @(negedge clk_i);
      check("hold_release_data", lsu_data_o, 32'hCAFEF00D);

      // 6b: killed load never issues
      lsu_flags_i = F_LW;
      lsu_kill_i  = 1'b1;
      #1 check("kill_stall", {31'd0, lsu_stall_o}, 32'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      check("kill_cyc", {31'd0, dwb_cyc_o}, 32'd0);
      lsu_flags_i = '0;
      lsu_kill_i  = 1'b0;

      // 6c: reset mid-BUS, late ack ignored
      issue(F_SH, 32'h602, 32'h0000BEEF);
      rst_ni = 1'b0;
      #1 check("rbus_stall", {31'd0, lsu_stall_o}, 32'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      check("rbus_cyc", {31'd0, dwb_cyc_o}, 32'd0);
      check("rbus_stb", {31'd0, dwb_stb_o}, 32'd0);
      check("rbus_we", {31'd0, dwb_we_o}, 32'd0);
      check("rbus_sel", {28'd0, dwb_sel_o}, 32'd0);
      check("rbus_addr", dwb_addr_o, 32'd0);
      check("rbus_dat", dwb_dat_o, 32'd0);
      check("rbus_data", lsu_data_o, 32'd0);
      dwb_ack_i = 1'b1;
      dwb_dat_i = 32'h77777777;
      rst_ni    = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      dwb_ack_i = 1'b0;
      check("late_ack_cyc", {31'd0, dwb_cyc_o}, 32'd0);
      check("late_ack_data", lsu_data_o, 32'd0);
      check("late_ack_err", {31'd0, lsu_err_o}, 32'd0);
      check("late_ack_stall", {31'd0, lsu_stall_o}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
